// File: rtl/aes_inv_iter_ctrl.sv
// -----------------------------------------------------------------------------
// aes_inv_iter_ctrl
//
// Iterative AES inverse cipher. One 128-bit state register evaluates one
// inverse round per clock: InvShiftRows -> InvSubBytes -> AddRoundKey ->
// InvMixColumns. The final round skips InvMixColumns. Round keys come from an
// external combinational key store addressed by key_idx.
//
// Parameters
//   Nk : key length in 32-bit words (4, 6 or 8). Nr = Nk + 6 is derived.
//
// Ports
//   clk        in   1    rising-edge clock
//   rst        in   1    asynchronous active-high reset
//   abort      in   1    synchronous abort (only when AES_INV_ABORT_EN)
//   in_valid   in   1    ciphertext present
//   in_ready   out  1    engine idle and able to take ciphertext
//   in_data    in   128  ciphertext, byte 0 in [127:120]
//   key_idx    out  4    registered round-key index for the key store
//   round_key  in   128  round key w[key_idx], same cycle as key_idx
//   out_valid  out  1    plaintext valid
//   out_ready  in   1    consumer takes plaintext
//   out_data   out  128  plaintext
//   busy       out  1    high while rounds are being computed
//   dbg_state  out  2    FSM state (0 IDLE, 1 ROUND, 2 FINAL, 3 DONE)
//
// Optional feature macro: AES_INV_ABORT_EN (adds the abort input).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A valid source holds valid and data stable until that edge;
// ready never depends combinationally on valid. in_valid is ignored while
// in_ready is low (nothing is buffered); out_ready is ignored while out_valid
// is low.
// -----------------------------------------------------------------------------
module aes_inv_iter_ctrl #(
  parameter int Nk = 4
) (
  input  logic         clk,
  input  logic         rst,
`ifdef AES_INV_ABORT_EN
  input  logic         abort,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   key_idx,
  input  logic [127:0] round_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  localparam int         Nr    = Nk + 6;
  localparam logic [3:0] NR_K  = 4'(Nr);
  localparam logic [3:0] NR_M1 = 4'(Nr - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // GF(2^8) helpers. The inverse S-box is written as the inverse affine map
  // followed by field inversion so it stays tied to its definition; synthesis
  // folds each instance into a constant table.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] y;
    r = 8'h01;
    y = x;
    for (int i = 1; i < 8; i++) begin
      y = gf_mul(y, y);
      r = gf_mul(r, y);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  // Byte n = row + 4*col sits at [127-8n -: 8]. Row r rotates right by r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c - r + 4) % 4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) begin
      o[127 - 8 * n -: 8] = inv_sbox(s[127 - 8 * n -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      o[127 - 32 * c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119 - 32 * c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111 - 32 * c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103 - 32 * c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t       r_fsm;
  logic [127:0] r_state;
  logic [3:0]   r_rcnt;
  logic [3:0]   r_key_idx;
  logic         r_out_valid;
  logic [127:0] r_out;

  state_t       w_fsm_nxt;
  logic [127:0] w_state_nxt;
  logic [3:0]   w_rcnt_nxt;
  logic [3:0]   w_key_idx_nxt;
  logic         w_out_valid_nxt;
  logic [127:0] w_out_nxt;

  // Round datapath, shared by ROUND and FINAL.
  logic [127:0] w_isr;
  logic [127:0] w_isb;
  logic [127:0] w_ark;
  logic [127:0] w_imc;

  assign w_isr = inv_shift_rows(r_state);
  assign w_isb = inv_sub_bytes(w_isr);
  assign w_ark = w_isb ^ round_key;
  assign w_imc = inv_mix_columns(w_ark);

  // ---------------------------------------------------------------------------
  // FSM next-state / next-register logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_fsm_nxt       = r_fsm;
    w_state_nxt     = r_state;
    w_rcnt_nxt      = r_rcnt;
    w_key_idx_nxt   = r_key_idx;
    w_out_valid_nxt = r_out_valid;
    w_out_nxt       = r_out;

    case (r_fsm)
      S_IDLE: begin
        // key_idx already points at w[Nr], so round_key is the initial key.
        if (in_valid) begin
          w_state_nxt   = in_data ^ round_key;
          w_rcnt_nxt    = NR_M1;
          w_key_idx_nxt = NR_M1;
          w_fsm_nxt     = S_ROUND;
        end
      end
      S_ROUND: begin
        w_state_nxt = w_imc;
        if (r_rcnt == 4'd1) begin
          w_key_idx_nxt = 4'd0;
          w_fsm_nxt     = S_FINAL;
        end else begin
          w_rcnt_nxt    = r_rcnt - 4'd1;
          w_key_idx_nxt = r_rcnt - 4'd1;
        end
      end
      S_FINAL: begin
        w_state_nxt     = w_ark;
        w_out_nxt       = w_ark;
        w_out_valid_nxt = 1'b1;
        w_fsm_nxt       = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_key_idx_nxt   = NR_K;
          w_fsm_nxt       = S_IDLE;
        end
      end
      default: begin
        w_fsm_nxt = S_IDLE;
      end
    endcase

`ifdef AES_INV_ABORT_EN
    // Abort overrides everything, including a DONE handshake in the same cycle.
    if (abort && (r_fsm != S_IDLE)) begin
      w_fsm_nxt       = S_IDLE;
      w_state_nxt     = '0;
      w_out_valid_nxt = 1'b0;
      w_key_idx_nxt   = NR_K;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm       <= S_IDLE;
      r_state     <= '0;
      r_rcnt      <= NR_M1;
      r_key_idx   <= NR_K;
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else begin
      r_fsm       <= w_fsm_nxt;
      r_state     <= w_state_nxt;
      r_rcnt      <= w_rcnt_nxt;
      r_key_idx   <= w_key_idx_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out       <= w_out_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all decoded from registers, no combinational paths from inputs.
  // ---------------------------------------------------------------------------
  assign in_ready  = (r_fsm == S_IDLE);
  assign busy      = (r_fsm == S_ROUND) || (r_fsm == S_FINAL);
  assign key_idx   = r_key_idx;
  assign out_valid = r_out_valid;
  assign out_data  = r_out;
  assign dbg_state = r_fsm;

endmodule

// File: tb/tb_aes_inv_iter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_inv_iter_ctrl
//
// Two engines (Nk=4 and Nk=8) each fed by a combinational key store that the
// bench expands from the cipher key. Known-answer vectors are applied from a
// table; hand-written sequences cover backpressure, back-to-back blocks,
// reset mid-block and (when AES_INV_ABORT_EN is defined) abort.
// -----------------------------------------------------------------------------
module tb_aes_inv_iter_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // index 0 : Nk=4 engine, index 1 : Nk=8 engine
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic [127:0] in_data   [2];
  logic [3:0]   key_idx   [2];
  logic [127:0] round_key [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [127:0] out_data  [2];
  logic         busy      [2];
  logic [1:0]   dbg_state [2];
`ifdef AES_INV_ABORT_EN
  logic         abort     [2];
`endif

  logic [127:0] ks [2][16];

  assign round_key[0] = ks[0][key_idx[0]];
  assign round_key[1] = ks[1][key_idx[1]];

  aes_inv_iter_ctrl #(.Nk(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
`ifdef AES_INV_ABORT_EN
    .abort     (abort[0]),
`endif
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .in_data   (in_data[0]),
    .key_idx   (key_idx[0]),
    .round_key (round_key[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .out_data  (out_data[0]),
    .busy      (busy[0]),
    .dbg_state (dbg_state[0])
  );

  aes_inv_iter_ctrl #(.Nk(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
`ifdef AES_INV_ABORT_EN
    .abort     (abort[1]),
`endif
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .in_data   (in_data[1]),
    .key_idx   (key_idx[1]),
    .round_key (round_key[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .out_data  (out_data[1]),
    .busy      (busy[1]),
    .dbg_state (dbg_state[1])
  );

  // ---------------- counters / scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [127:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every output handshake pops one expected plaintext.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst && out_valid[d] && out_ready[d]) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: dut %0d produced %h with nothing expected", d, out_data[d]);
        end else begin
          logic [127:0] e;
          e = exp_q.pop_front();
          if (out_data[d] !== e) begin
            n_fail++;
            $display("FAIL sb_data: dut %0d got %h expected %h", d, out_data[d], e);
          end
        end
      end
    end
  end

  // ---------------- key expansion model ----------------
  function automatic logic [7:0] m_xtime(input logic [7:0] a);
    return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = m_xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] y;
    r = 8'h01;
    y = x;
    for (int i = 1; i < 8; i++) begin
      y = m_mul(y, y);
      r = m_mul(r, y);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {m_sbox(w[31:24]), m_sbox(w[23:16]), m_sbox(w[15:8]), m_sbox(w[7:0])};
  endfunction

  // key is MSB-aligned: word j = key[255-32j -: 32]
  task automatic load_keys(input int d, input logic [255:0] key, input int nk);
    logic [31:0] w [64];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 64; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i - 1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = m_xtime(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i - nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      ks[d][r] = (r <= nr) ? {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]} : '0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_block(input int d, input logic [127:0] ct, input logic [127:0] pt, input int nr);
    int w;
    w = 0;
    while (!in_ready[d] && w < 50) begin
      tick();
      w++;
    end
    check("in_ready_before_accept", 128'(in_ready[d]), 128'(1));
    check("key_idx_idle", 128'(key_idx[d]), 128'(nr));
    in_valid[d] = 1'b1;
    in_data[d]  = ct;
    exp_q.push_back(pt);
    tick();
    in_valid[d] = 1'b0;
    check("busy_after_accept", 128'(busy[d]), 128'(1));
    check("in_ready_after_accept", 128'(in_ready[d]), 128'(0));
  endtask

  // Called right after the accepting edge; returns edges until out_valid.
  task automatic wait_out(input int d, input int nr, output int lat);
    lat = 0;
    while (!out_valid[d] && lat < 40) begin
      if (lat < nr) check($sformatf("key_idx_seq_%0d", lat), 128'(key_idx[d]), 128'(nr - 1 - lat));
      tick();
      lat++;
    end
  endtask

  typedef struct {
    int           d;
    int           nk;
    logic [255:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    int           lat;
  } vec_t;

  vec_t vecs [4];

  task automatic run_vec(input vec_t v);
    int lat;
    load_keys(v.d, v.key, v.nk);
    out_ready[v.d] = 1'b1;
    start_block(v.d, v.ct, v.pt, v.nk + 6);
    wait_out(v.d, v.nk + 6, lat);
    check("latency", 128'(lat), 128'(v.lat));
    check("out_data", out_data[v.d], v.pt);
    tick();
    check("out_valid_after_hs", 128'(out_valid[v.d]), 128'(0));
    check("in_ready_after_hs", 128'(in_ready[v.d]), 128'(1));
    check("key_idx_after_hs", 128'(key_idx[v.d]), 128'(v.nk + 6));
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int lat;
    int cyc;
    int accepts;
    int acc_t [2];
    int cnt;

    vecs[0] = '{0, 4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, 10};
    vecs[1] = '{0, 4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734, 10};
    vecs[2] = '{0, 4, 256'h0,
                128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0, 10};
    vecs[3] = '{1, 8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h8ea2b7ca516745bfeafc49904b496089, 128'h00112233445566778899aabbccddeeff, 14};

    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      in_data[d]   = '0;
      out_ready[d] = 1'b0;
`ifdef AES_INV_ABORT_EN
      abort[d]     = 1'b0;
`endif
    end
    for (int d = 0; d < 2; d++) for (int r = 0; r < 16; r++) ks[d][r] = '0;

    // reset values
    rst = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("rst_in_ready", 128'(in_ready[0]), 128'(1));
    check("rst_out_valid", 128'(out_valid[0]), 128'(0));
    check("rst_busy", 128'(busy[0]), 128'(0));
    check("rst_key_idx4", 128'(key_idx[0]), 128'(10));
    check("rst_key_idx8", 128'(key_idx[1]), 128'(14));
    check("rst_out_data", out_data[0], 128'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // known-answer vectors
    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // backpressure: consumer stalls 5 cycles, a second ciphertext is offered
    load_keys(0, vecs[0].key, 4);
    out_ready[0] = 1'b0;
    start_block(0, vecs[0].ct, vecs[0].pt, 10);
    wait_out(0, 10, lat);
    check("bp_latency", 128'(lat), 128'(10));
    in_valid[0] = 1'b1;
    in_data[0]  = vecs[1].ct;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_out_valid_held", 128'(out_valid[0]), 128'(1));
      check("bp_out_data_held", out_data[0], vecs[0].pt);
      check("bp_in_ready_low", 128'(in_ready[0]), 128'(0));
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    tick();
    check("bp_out_valid_drop", 128'(out_valid[0]), 128'(0));
    check("bp_in_ready_back", 128'(in_ready[0]), 128'(1));
    tick();
    check("bp_not_buffered", 128'(busy[0]), 128'(0));

    // back-to-back with in_valid held
    load_keys(0, vecs[0].key, 4);
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    in_data[0]   = vecs[0].ct;
    accepts = 0;
    cyc     = 0;
    acc_t[0] = 0;
    acc_t[1] = 0;
    while (accepts < 2 && cyc < 60) begin
      if (in_ready[0]) begin
        acc_t[accepts] = cyc;
        accepts++;
        exp_q.push_back(vecs[0].pt);
      end
      tick();
      cyc++;
    end
    in_valid[0] = 1'b0;
    check("b2b_accepts", 128'(accepts), 128'(2));
    check("b2b_spacing", 128'(acc_t[1] - acc_t[0]), 128'(12));
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 40) begin
      tick();
      cnt++;
    end
    check("b2b_drained", 128'(exp_q.size()), 128'(0));
    tick();

    // reset at cycle 5 of a block
    start_block(0, vecs[0].ct, vecs[0].pt, 10);
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    #1;
    void'(exp_q.pop_back());
    check("mid_rst_in_ready", 128'(in_ready[0]), 128'(1));
    check("mid_rst_out_valid", 128'(out_valid[0]), 128'(0));
    check("mid_rst_busy", 128'(busy[0]), 128'(0));
    check("mid_rst_key_idx", 128'(key_idx[0]), 128'(10));
    check("mid_rst_out_data", out_data[0], 128'h0);
    tick();
    tick();
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (out_valid[0]) cnt++;
    end
    check("mid_rst_no_out", 128'(cnt), 128'(0));
    run_vec(vecs[0]);

`ifdef AES_INV_ABORT_EN
    // abort at cycle 4 of a block
    load_keys(0, vecs[0].key, 4);
    start_block(0, vecs[0].ct, vecs[0].pt, 10);
    for (int k = 0; k < 4; k++) tick();
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    void'(exp_q.pop_back());
    check("abort_state_idle", 128'(dbg_state[0]), 128'(0));
    check("abort_in_ready", 128'(in_ready[0]), 128'(1));
    check("abort_key_idx", 128'(key_idx[0]), 128'(10));
    check("abort_busy", 128'(busy[0]), 128'(0));
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (out_valid[0]) cnt++;
    end
    check("abort_no_out", 128'(cnt), 128'(0));
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    check("abort_idle_noeffect", 128'(in_ready[0]), 128'(1));
    run_vec(vecs[0]);
`endif

    check("sb_empty", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_inv_iter_ctrl.md
Name: aes_inv_iter_ctrl

Overview:
- Iterative AES inverse-cipher engine: one 128-bit state register, one inverse round evaluated per clock.
- Sequences the existing combinational blocks InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns over Nr rounds instead of unrolling them.
- Fetches round keys from an external key store by index.
- Valid/ready handshake on input and output; sits between the key-schedule storage and the system bus wrapper.

Parameters:
- Nk, 4, key length in 32-bit words; legal values 4, 6, 8.
- Nr, Nk+6, number of rounds; derived, never overridden independently.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  ciphertext present.
- in_ready  output  1  engine can accept ciphertext.
- in_data  input  128  ciphertext, FIPS-197 byte order (byte 0 in [127:120]).
- key_idx  output  4  round-key index requested from key store.
- round_key  input  128  round key w[key_idx]; valid in the same cycle as key_idx (combinational store).
- out_valid  output  1  plaintext valid.
- out_ready  input  1  consumer accepts plaintext.
- out_data  output  128  plaintext.
- busy  output  1  high in ROUND or FINAL.

Behaviour:
- Reset values (async, while rst=1): state=IDLE, in_ready=1, out_valid=0, busy=0, key_idx=Nr, out_data=0, round counter=Nr-1.
- FSM states: IDLE, ROUND, FINAL, DONE.
- IDLE:
  - in_ready=1, key_idx=Nr.
  - On in_valid&in_ready: state_reg <= in_data ^ round_key, rcnt <= Nr-1, key_idx <= Nr-1, go to ROUND.
- ROUND:
  - Each cycle: state_reg <= InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) ^ round_key), with key_idx=rcnt.
  - If rcnt==1: go to FINAL, key_idx <= 0.
  - Otherwise: rcnt <= rcnt-1, key_idx <= rcnt-1.
- FINAL:
  - state_reg <= InvSubBytes(InvShiftRows(state_reg)) ^ round_key (key_idx=0), no InvMixColumns.
  - Go to DONE; out_valid <= 1.
- DONE:
  - out_valid=1, out_data=state_reg, both held stable until out_ready.
  - On out_valid&out_ready: out_valid <= 0, key_idx <= Nr, go to IDLE.
- Latency: out_valid rises exactly Nr cycles after the accepting edge (10/12/14 for Nk=4/6/8).
- Throughput: one block per Nr+2 cycles with out_ready held high.
- in_ready=0 in ROUND, FINAL and DONE. in_valid is ignored there and the input is not buffered.
- out_ready while out_valid=0: ignored.
- key_idx is registered and glitch-free; the key store must not be rewritten while busy=1. This is the user's responsibility and is not checked.
- rcnt width is 4 bits; it never wraps because it stops at 1.
- out_data changes only on the FINAL→DONE edge.
- Reset asserted mid-operation: immediate return to reset values. The partial block is discarded and no out_valid is produced.

Optional Feature:
- Macro: AES_INV_ABORT_EN.
- When defined:
  - Adds port abort (input, 1), sampled synchronously.
  - abort=1 in ROUND, FINAL or DONE: next cycle state=IDLE, out_valid=0, key_idx=Nr, state_reg cleared to 0.
  - abort in IDLE: no effect.
  - abort has priority over out_ready in DONE.
- When undefined: no abort port; blocks always run to completion.

Test Plan:
- Nk=4, FIPS-197 C.1: ct 69c4e0d86a7b0430d8cdb78070b4c55a, keys expanded from 000102030405060708090a0b0c0d0e0f → out_data 00112233445566778899aabbccddeeff, out_valid exactly 10 cycles after accept; key_idx sequence 10,9,…,0.
- Nk=8, FIPS-197 C.3: ct 8ea2b7ca516745bfeafc49904b496089, key 000102…1f → pt 00112233445566778899aabbccddeeff after 14 cycles.
- Backpressure: out_ready=0 for 5 cycles after out_valid → out_data/out_valid stable, in_ready=0, second in_valid not accepted. Release → one-cycle handshake, in_ready=1 the next cycle.
- Back-to-back: two C.1 blocks with out_ready=1 and in_valid held → second accept exactly 12 cycles after the first, both outputs correct.
- Reset at cycle 5 of a block → all outputs at reset values immediately, no out_valid. The next block decrypts correctly.
- AES_INV_ABORT_EN: abort at cycle 4 → IDLE next cycle, out_valid never rises, key_idx=10. The following C.1 block is correct.
